// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction, write-back source select
// and register-file write port, with load-wait stall and misaligned-load flagging.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] Data_read,
  input  logic            d_ready,
  input  logic            su,
  input  logic [1:0]      whb,
  input  logic [1:0]      wos,
  input  logic            lt,
  input  logic            ltu,
  input  logic [XLEN-1:0] PC_4,
  input  logic            flush,
  output logic            stall_MEM,
  output logic            reg_wr_en,
  output logic [4:0]      rd_WB,
  output logic [XLEN-1:0] wb_data_WB,
  output logic            misaligned_WB,
  output logic            valid_WB
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Pick the addressed lane of the read word and extend it to the full width.
  function automatic logic [XLEN-1:0] extract_load(
    input logic [XLEN-1:0] word,
    input logic [1:0]      off,
    input logic [1:0]      size,
    input logic            sgn
  );
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] res_v;
    case (off)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      2'b11:   byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    if (off[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (size)
      2'b00:   res_v = {{(XLEN-8){sgn & byte_v[7]}}, byte_v};
      2'b01:   res_v = {{(XLEN-16){sgn & half_v[15]}}, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  logic            is_load_s;
  logic            stall_s;
  logic            capture_s;
  logic            misaligned_s;
  logic            wr_en_s;
  logic [XLEN-1:0] load_data_s;
  logic [XLEN-1:0] wb_sel_s;

  logic            reg_wr_en_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] wb_data_r;
  logic            misaligned_r;
  logic            valid_r;

  // Stall/capture decision, misalignment check and write-back source mux.
  always_comb begin
    is_load_s    = (opcode == OP_LOAD);
    stall_s      = valid_in & is_load_s & ~d_ready & ~flush;
    capture_s    = valid_in & ~stall_s & ~flush;
    misaligned_s = 1'b0;
    if (is_load_s) begin
      case (whb)
        2'b00:   misaligned_s = 1'b0;
        2'b01:   misaligned_s = result[0];
        default: misaligned_s = |result[1:0];
      endcase
    end else begin
      misaligned_s = 1'b0;
    end
    load_data_s = extract_load(Data_read, result[1:0], whb, su);
    case (wos)
      2'b00:   wb_sel_s = result;
      2'b01:   wb_sel_s = load_data_s;
      2'b10:   wb_sel_s = PC_4;
      default: wb_sel_s = {{(XLEN-1){1'b0}}, (su ? lt : ltu)};
    endcase
    wr_en_s = (opcode != OP_STORE) & (opcode != OP_BRANCH) &
              (rd_addr != 5'd0) & ~misaligned_s;
  end

  // MEM/WB register; a bubble clears the control bits and keeps the data fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_en_r  <= 1'b0;
      rd_r         <= 5'd0;
      wb_data_r    <= {XLEN{1'b0}};
      misaligned_r <= 1'b0;
      valid_r      <= 1'b0;
    end else if (capture_s) begin
      reg_wr_en_r  <= wr_en_s;
      rd_r         <= rd_addr;
      wb_data_r    <= wb_sel_s;
      misaligned_r <= misaligned_s;
      valid_r      <= 1'b1;
    end else begin
      reg_wr_en_r  <= 1'b0;
      misaligned_r <= 1'b0;
      valid_r      <= 1'b0;
    end
  end

  assign stall_MEM     = stall_s;
  assign reg_wr_en     = reg_wr_en_r;
  assign rd_WB         = rd_r;
  assign wb_data_WB    = wb_data_r;
  assign misaligned_WB = misaligned_r;
  assign valid_WB      = valid_r;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed vector table, multi-cycle stall/flush/reset sequences
// and randomized traffic against a behavioural model.
module tb_wb_stage;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;

  typedef struct packed {
    logic        rst;
    logic        valid_in;
    logic [6:0]  opcode;
    logic [4:0]  rd_addr;
    logic [31:0] result;
    logic [31:0] data_read;
    logic        d_ready;
    logic        su;
    logic [1:0]  whb;
    logic [1:0]  wos;
    logic        lt;
    logic        ltu;
    logic [31:0] pc_4;
    logic        flush;
    logic        e_stall;
    logic        e_valid;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, valid_in, d_ready, su, lt, ltu, flush;
  logic [6:0]  opcode;
  logic [4:0]  rd_addr;
  logic [31:0] result, Data_read, PC_4;
  logic [1:0]  whb, wos;
  logic        stall_MEM, reg_wr_en, misaligned_WB, valid_WB;
  logic [4:0]  rd_WB;
  logic [31:0] wb_data_WB;

  int checks = 0;
  int errors = 0;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode), .rd_addr(rd_addr),
    .result(result), .Data_read(Data_read), .d_ready(d_ready), .su(su), .whb(whb),
    .wos(wos), .lt(lt), .ltu(ltu), .PC_4(PC_4), .flush(flush), .stall_MEM(stall_MEM),
    .reg_wr_en(reg_wr_en), .rd_WB(rd_WB), .wb_data_WB(wb_data_WB),
    .misaligned_WB(misaligned_WB), .valid_WB(valid_WB)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic v, input logic [6:0] op, input logic [4:0] rd,
    input logic [31:0] res, input logic [31:0] dr, input logic dy, input logic s,
    input logic [1:0] sz, input logic [1:0] src, input logic l, input logic lu,
    input logic [31:0] pc, input logic fl,
    input logic es, input logic ev, input logic ew, input logic [4:0] erd,
    input logic [31:0] ed, input logic em);
    vec_t t;
    t.rst = r; t.valid_in = v; t.opcode = op; t.rd_addr = rd; t.result = res;
    t.data_read = dr; t.d_ready = dy; t.su = s; t.whb = sz; t.wos = src;
    t.lt = l; t.ltu = lu; t.pc_4 = pc; t.flush = fl;
    t.e_stall = es; t.e_valid = ev; t.e_wr = ew; t.e_rd = erd; t.e_data = ed; t.e_mis = em;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; valid_in = v.valid_in; opcode = v.opcode; rd_addr = v.rd_addr;
    result = v.result; Data_read = v.data_read; d_ready = v.d_ready; su = v.su;
    whb = v.whb; wos = v.wos; lt = v.lt; ltu = v.ltu; PC_4 = v.pc_4; flush = v.flush;
    #1;
    chk({tag, ".stall"}, {31'd0, stall_MEM}, {31'd0, v.e_stall});
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'd0, valid_WB}, {31'd0, v.e_valid});
    chk({tag, ".wr_en"}, {31'd0, reg_wr_en}, {31'd0, v.e_wr});
    chk({tag, ".rd"}, {27'd0, rd_WB}, {27'd0, v.e_rd});
    chk({tag, ".data"}, wb_data_WB, v.e_data);
    chk({tag, ".mis"}, {31'd0, misaligned_WB}, {31'd0, v.e_mis});
  endtask

  // Reference: derives the expected outputs from the stage's architectural rules.
  task automatic model_fill(inout vec_t v);
    int nbytes, off, lane;
    logic [31:0] mask, val, src;
    logic lmis;
    v.e_stall = v.valid_in && (v.opcode == LD) && !v.d_ready && !v.flush;
    if (v.rst) begin
      m_rd = 5'd0; m_data = 32'd0;
      v.e_valid = 1'b0; v.e_wr = 1'b0; v.e_mis = 1'b0;
    end else if (v.valid_in && !v.e_stall && !v.flush) begin
      off    = int'(v.result[1:0]);
      nbytes = (v.whb == 2'b00) ? 1 : ((v.whb == 2'b01) ? 2 : 4);
      lmis   = (v.opcode == LD) && ((off % nbytes) != 0);
      lane   = (nbytes == 4) ? 0 : (off / nbytes) * nbytes;
      mask   = 32'hFFFF_FFFF >> (32 - 8 * nbytes);
      val    = (v.data_read >> (8 * lane)) & mask;
      if (v.su && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
      case (v.wos)
        2'b00:   src = v.result;
        2'b01:   src = val;
        2'b10:   src = v.pc_4;
        default: src = v.su ? {31'd0, v.lt} : {31'd0, v.ltu};
      endcase
      m_rd = v.rd_addr; m_data = src;
      v.e_valid = 1'b1;
      v.e_mis   = lmis;
      v.e_wr    = (v.opcode != ST) && (v.opcode != BR) && (v.rd_addr != 5'd0) && !lmis;
    end else begin
      v.e_valid = 1'b0; v.e_wr = 1'b0; v.e_mis = 1'b0;
    end
    v.e_rd = m_rd;
    v.e_data = m_data;
  endtask

  localparam logic [31:0] DW = 32'h80FF_7F01;
  vec_t tbl[18];
  vec_t rv;
  logic [6:0] ops[7];

  initial begin
    rst = 1'b1; valid_in = 1'b0; opcode = 7'd0; rd_addr = 5'd0; result = 32'd0;
    Data_read = 32'd0; d_ready = 1'b1; su = 1'b0; whb = 2'b00; wos = 2'b00;
    lt = 1'b0; ltu = 1'b0; PC_4 = 32'd0; flush = 1'b0;

    // reset held two cycles with a valid instruction present, then first capture
    run_vec(mk(1,1,OPR,5,32'h7,0,1,0,0,0,0,0,0,0, 0,0,0,0,32'h0,0), "rst0");
    run_vec(mk(1,1,OPR,5,32'h7,0,1,0,0,0,0,0,0,0, 0,0,0,0,32'h0,0), "rst1");
    run_vec(mk(0,1,OPR,5,32'h7,0,1,0,0,0,0,0,0,0, 0,1,1,5,32'h7,0), "first");

    tbl[0]  = mk(0,1,LD ,5 ,32'h103 ,DW,1,1,2'b00,2'b01,0,0,0,0, 0,1,1,5 ,32'hFFFF_FF80,0);
    tbl[1]  = mk(0,1,OPR,7 ,32'h9   ,DW,1,0,2'b00,2'b10,0,0,32'h44,0, 0,1,1,7 ,32'h44,0);
    tbl[2]  = mk(0,1,OPR,8 ,32'h9   ,DW,1,0,2'b00,2'b11,0,1,0,0, 0,1,1,8 ,32'h1,0);
    tbl[3]  = mk(0,1,OPR,8 ,32'h9   ,DW,1,1,2'b00,2'b11,1,0,0,0, 0,1,1,8 ,32'h1,0);
    tbl[4]  = mk(0,1,OPR,8 ,32'h9   ,DW,1,1,2'b00,2'b11,0,1,0,0, 0,1,1,8 ,32'h0,0);
    tbl[5]  = mk(0,1,OPI,0 ,32'h1234,DW,1,0,2'b00,2'b00,0,0,0,0, 0,1,0,0 ,32'h1234,0);
    tbl[6]  = mk(0,1,ST ,3 ,32'h55  ,DW,1,0,2'b10,2'b00,0,0,0,0, 0,1,0,3 ,32'h55,0);
    tbl[7]  = mk(0,1,BR ,4 ,32'h66  ,DW,1,0,2'b00,2'b00,0,0,0,0, 0,1,0,4 ,32'h66,0);
    tbl[8]  = mk(0,1,LD ,9 ,32'h201 ,DW,1,0,2'b10,2'b01,0,0,0,0, 0,1,0,9 ,DW,1);
    tbl[9]  = mk(0,1,LD ,10,32'h100 ,DW,1,1,2'b01,2'b01,0,0,0,0, 0,1,1,10,32'h0000_7F01,0);
    tbl[10] = mk(0,1,LD ,11,32'h203 ,DW,1,1,2'b01,2'b01,0,0,0,0, 0,1,0,11,32'hFFFF_80FF,1);
    tbl[11] = mk(0,1,LD ,12,32'h300 ,DW,1,0,2'b11,2'b01,0,0,0,0, 0,1,1,12,DW,0);
    tbl[12] = mk(0,0,LD ,13,32'h0   ,DW,1,0,2'b00,2'b01,0,0,0,0, 0,0,0,12,DW,0);
    tbl[13] = mk(0,1,OPR,13,32'h77  ,DW,1,0,2'b00,2'b00,0,0,0,1, 0,0,0,12,DW,0);
    tbl[14] = mk(0,1,LD ,14,32'h101 ,DW,1,0,2'b00,2'b01,0,0,0,0, 0,1,1,14,32'h0000_007F,0);
    tbl[15] = mk(0,1,ST ,2 ,32'h203 ,DW,1,0,2'b10,2'b00,0,0,0,0, 0,1,0,2 ,32'h203,0);
    tbl[16] = mk(0,1,LD ,1 ,32'h100 ,DW,1,1,2'b00,2'b01,0,0,0,0, 0,1,1,1 ,32'h1,0);
    tbl[17] = mk(0,1,LD ,15,32'h102 ,DW,1,1,2'b01,2'b01,0,0,0,0, 0,1,1,15,32'hFFFF_80FF,0);
    for (int i = 0; i < 18; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // unsigned half load waiting three cycles for memory
    for (int i = 0; i < 3; i++)
      run_vec(mk(0,1,LD,6,32'h102,DW,0,0,2'b01,2'b01,0,0,0,0, 1,0,0,15,32'hFFFF_80FF,0),
              $sformatf("wait%0d", i));
    run_vec(mk(0,1,LD,6,32'h102,DW,1,0,2'b01,2'b01,0,0,0,0, 0,1,1,6,32'h0000_80FF,0), "waitdone");

    // flush beats stall; then a store retires without a write
    run_vec(mk(0,1,LD,7,32'h100,DW,0,0,2'b10,2'b01,0,0,0,1, 0,0,0,6,32'h0000_80FF,0), "flushld");
    run_vec(mk(0,1,ST,2,32'h10 ,DW,1,0,2'b10,2'b00,0,0,0,0, 0,1,0,2,32'h10,0), "store");

    // reset while a load is stalled drops it
    run_vec(mk(0,1,LD,9,32'h100,DW,0,0,2'b10,2'b01,0,0,0,0, 1,0,0,2,32'h10,0), "rststall0");
    run_vec(mk(1,1,LD,9,32'h100,DW,0,0,2'b10,2'b01,0,0,0,0, 1,0,0,0,32'h0,0), "rststall1");
    run_vec(mk(0,0,LD,9,32'h100,DW,1,0,2'b10,2'b01,0,0,0,0, 0,0,0,0,32'h0,0), "rststall2");

    // back-to-back loads, each waiting for its own ready
    run_vec(mk(0,1,LD,3,32'h100,32'h1122_3344,0,0,2'b10,2'b01,0,0,0,0, 1,0,0,0,32'h0,0), "b2b0");
    run_vec(mk(0,1,LD,3,32'h100,32'h1122_3344,1,0,2'b10,2'b01,0,0,0,0, 0,1,1,3,32'h1122_3344,0), "b2b1");
    run_vec(mk(0,1,LD,4,32'h104,32'hAABB_CCDD,0,0,2'b00,2'b01,0,0,0,0, 1,0,0,3,32'h1122_3344,0), "b2b2");
    run_vec(mk(0,1,LD,4,32'h104,32'hAABB_CCDD,0,0,2'b00,2'b01,0,0,0,0, 1,0,0,3,32'h1122_3344,0), "b2b3");
    run_vec(mk(0,1,LD,4,32'h104,32'hAABB_CCDD,1,0,2'b00,2'b01,0,0,0,0, 0,1,1,4,32'h0000_00DD,0), "b2b4");

    // randomized traffic against the model
    ops[0] = LD; ops[1] = LD; ops[2] = ST; ops[3] = BR; ops[4] = OPR; ops[5] = OPI; ops[6] = JAL;
    for (int i = 0; i < 500; i++) begin
      rv = '0;
      rv.rst       = (i == 0) || ($urandom_range(0, 39) == 0);
      rv.valid_in  = ($urandom_range(0, 7) != 0);
      rv.opcode    = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      rv.rd_addr   = 5'($urandom);
      rv.result    = $urandom;
      rv.data_read = $urandom;
      rv.d_ready   = ($urandom_range(0, 2) != 0);
      rv.su        = 1'($urandom);
      rv.whb       = 2'($urandom);
      rv.wos       = 2'($urandom);
      rv.lt        = 1'($urandom);
      rv.ltu       = 1'($urandom);
      rv.pc_4      = $urandom;
      rv.flush     = ($urandom_range(0, 9) == 0);
      model_fill(rv);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
